// File: rtl/cla16_accumulator.sv
// ---------------------------------------------------------------------------
// cla16_accumulator
//
// Sums a run of `len` unsigned 16-bit operands taken from a valid/ready
// input stream and presents the total, plus a sticky carry-out flag, on a
// valid/ready output. Every add goes through a two-level carry-lookahead
// adder (cla16, defined below in this file).
//
// Optional feature:
//   CLA_ACC_SAT_EN  when defined, an add that carries out loads the
//                   accumulator with 16'hFFFF instead of the wrapped sum.
//                   Without the macro the sum wraps modulo 2^16.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both 1. valid/ready never depend on each other
// combinationally, and rst blocks every transfer in the cycle it is high.
//
// Ports (cla16_accumulator):
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin an accumulation (honoured only in IDLE)
//   len        in   LEN_W operand count, sampled with start (0 allowed)
//   in_valid   in   operand valid
//   in_data    in   16-bit unsigned operand
//   in_ready   out  operand accepted this cycle when in_valid is high
//   out_valid  out  result available
//   out_ready  in   downstream takes the result
//   out_sum    out  accumulator register
//   out_ovf    out  sticky carry-out register
//   busy       out  state is not IDLE
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla16: 16-bit carry-lookahead adder.
// Four 4-bit groups; each group produces a group generate/propagate pair,
// the group carries are computed in parallel from those pairs, and each
// group then resolves its internal bit carries from its own carry-in.
//   a, b  in   addends
//   cin   in   carry in
//   s     out  sum
//   c     out  carry out of bit 15
// ---------------------------------------------------------------------------
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        c
);

  logic [15:0] g;   // bit generate
  logic [15:0] p;   // bit propagate
  logic [3:0]  gg;  // group generate
  logic [3:0]  gp;  // group propagate
  logic [4:0]  gc;  // group carry-in; gc[4] is the final carry out
  logic [15:0] bc;  // carry into each bit

  always_comb begin
    g = a & b;
    p = a ^ b;

    // Group generate / propagate over bits [4k+3 : 4k].
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end

    // Second-level lookahead: every group carry is a flat sum of products.
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    // First-level lookahead inside each group.
    bc = '0;
    for (int k = 0; k < 4; k++) begin
      bc[4*k]   = gc[k];
      bc[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      bc[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                | (p[4*k+1] & p[4*k] & gc[k]);
      bc[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                | (p[4*k+2] & p[4*k+1] & g[4*k])
                | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end

    s = p ^ bc;
    c = gc[4];
  end

endmodule

// ---------------------------------------------------------------------------
// cla16_accumulator: control FSM (IDLE -> ACC -> DONE -> IDLE) around cla16.
// ---------------------------------------------------------------------------
module cla16_accumulator #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;

  logic [15:0]      cla_s;
  logic             cla_c;
  logic             in_beat;
  logic             out_beat;

  // The single adder: accumulator + incoming operand.
  cla16 u_cla16 (
    .a   (acc_q),
    .b   (in_data),
    .cin (1'b0),
    .s   (cla_s),
    .c   (cla_c)
  );

  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid && out_ready;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      remaining_q <= remaining_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // A zero-length run skips ACC and reports the cleared sum.
        if (start) state_d = (len == '0) ? S_DONE : S_ACC;
      end
      S_ACC: begin
        if (in_beat && (remaining_q == LEN_W'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d       = '0;
          ovf_d       = 1'b0;
          remaining_d = len;
        end
      end
      S_ACC: begin
        if (in_beat) begin
`ifdef CLA_ACC_SAT_EN
          // Clamp on carry-out. Once acc is 16'hFFFF any non-zero operand
          // carries again and a zero operand leaves it unchanged, so the
          // clamp holds for the rest of the run without extra state.
          acc_d = cla_c ? 16'hFFFF : cla_s;
`else
          acc_d = cla_s;
`endif
          ovf_d       = ovf_q | cla_c;
          remaining_d = remaining_q - LEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs. Handshake strobes are masked by rst so no transfer can happen
  // in a reset cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_ACC)  && !rst;
    out_valid = (state_q == S_DONE) && !rst;
    busy      = (state_q != S_IDLE);
    out_sum   = acc_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_cla16_accumulator.sv
// ---------------------------------------------------------------------------
// tb_cla16_accumulator
//
// Directed bench for cla16_accumulator. A table of {len, operands, expected
// sum/ovf} records is run back to back with out_ready held high, followed by
// hand-written sequences for stalls, gaps, ignored start and mid-run reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_cla16_accumulator;

  localparam int LEN_W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic             out_ovf;
  logic             busy;

  always #5 clk = ~clk;

  cla16_accumulator #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [LEN_W-1:0]  len;
    logic [3:0][15:0]  ops;
    logic [15:0]       sum_wrap;
    logic [15:0]       sum_sat;
    logic              ovf;
  } vec_t;

  function automatic logic [15:0] pick_sum(input vec_t v);
`ifdef CLA_ACC_SAT_EN
    return v.sum_sat;
`else
    return v.sum_wrap;
`endif
  endfunction

  // One full transaction with back-to-back operands and out_ready high.
  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] exp_sum;
    exp_q.push_back(pick_sum(v));
    check($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
    start     = 1'b1;
    len       = v.len;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      check($sformatf("v%0d in_ready[%0d]", idx, i), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = v.ops[i];
      step();
    end
    in_valid = 1'b0;
    in_data  = 16'h0;
    exp_sum  = exp_q.pop_front();
    check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
    check($sformatf("v%0d in_ready_done", idx), 32'(in_ready), 32'd0);
    check($sformatf("v%0d out_sum", idx), 32'(out_sum), 32'(exp_sum));
    check($sformatf("v%0d out_ovf", idx), 32'(out_ovf), 32'(v.ovf));
    step();
    check($sformatf("v%0d out_valid_drop", idx), 32'(out_valid), 32'd0);
    check($sformatf("v%0d busy_after", idx), 32'(busy), 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  vec_t vecs[10];

  initial begin
    vecs[0] = '{len: 8'd3, ops: {16'd0, 16'd3000, 16'd2000, 16'd1000},
                sum_wrap: 16'd6000, sum_sat: 16'd6000, ovf: 1'b0};
    vecs[1] = '{len: 8'd2, ops: {16'd0, 16'd0, 16'd57458, 16'd48973},
                sum_wrap: 16'd40895, sum_sat: 16'd65535, ovf: 1'b1};
    vecs[2] = '{len: 8'd1, ops: {16'd0, 16'd0, 16'd0, 16'd7},
                sum_wrap: 16'd7, sum_sat: 16'd7, ovf: 1'b0};
    vecs[3] = '{len: 8'd4, ops: {16'd5, 16'd0, 16'h0001, 16'hFFFF},
                sum_wrap: 16'd5, sum_sat: 16'hFFFF, ovf: 1'b1};
    vecs[4] = '{len: 8'd4, ops: {16'h0001, 16'h2222, 16'h1111, 16'h1234},
                sum_wrap: 16'h4568, sum_sat: 16'h4568, ovf: 1'b0};
    vecs[5] = '{len: 8'd2, ops: {16'd0, 16'd0, 16'h8000, 16'h8000},
                sum_wrap: 16'h0000, sum_sat: 16'hFFFF, ovf: 1'b1};
    vecs[6] = '{len: 8'd0, ops: {16'd0, 16'd0, 16'd0, 16'd0},
                sum_wrap: 16'h0000, sum_sat: 16'h0000, ovf: 1'b0};
    vecs[7] = '{len: 8'd4, ops: {16'h0000, 16'h0000, 16'h5555, 16'hAAAA},
                sum_wrap: 16'hFFFF, sum_sat: 16'hFFFF, ovf: 1'b0};
    vecs[8] = '{len: 8'd2, ops: {16'd0, 16'd0, 16'h0001, 16'h7FFF},
                sum_wrap: 16'h8000, sum_sat: 16'h8000, ovf: 1'b0};
    vecs[9] = '{len: 8'd3, ops: {16'd0, 16'h0001, 16'hF0F0, 16'h0F0F},
                sum_wrap: 16'h0000, sum_sat: 16'hFFFF, ovf: 1'b1};

    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_sum", 32'(out_sum), 32'd0);
    check("rst out_ovf", 32'(out_ovf), 32'd0);

    // Reset wins over start.
    rst   = 1'b1;
    start = 1'b1;
    len   = 8'd2;
    step();
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check("rst_prio busy", 32'(busy), 32'd0);

    // Table of back-to-back transactions.
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Gaps in in_valid, stalled output, start pulsed during DONE.
    begin
      logic [15:0] gap_ops[8];
      logic        gap_vld[8];
      logic [15:0] partial;
      gap_ops = '{16'd100, 16'd9999, 16'd200, 16'd8888, 16'd7777,
                  16'd300, 16'd6666, 16'd400};
      gap_vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      partial = 16'd0;
      out_ready = 1'b0;
      start     = 1'b1;
      len       = 8'd4;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        check($sformatf("gap in_ready[%0d]", i), 32'(in_ready), 32'd1);
        check($sformatf("gap partial[%0d]", i), 32'(out_sum), 32'(partial));
        in_valid = gap_vld[i];
        in_data  = gap_ops[i];
        if (gap_vld[i]) partial = partial + gap_ops[i];
        step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
        check($sformatf("stall out_valid[%0d]", i), 32'(out_valid), 32'd1);
        check($sformatf("stall out_sum[%0d]", i), 32'(out_sum), 32'd1000);
        check($sformatf("stall out_ovf[%0d]", i), 32'(out_ovf), 32'd0);
        start = (i == 2);
        len   = 8'd2;
        step();
      end
      start     = 1'b0;
      out_ready = 1'b1;
      check("stall release out_valid", 32'(out_valid), 32'd1);
      step();
      check("stall after out_valid", 32'(out_valid), 32'd0);
      check("stall after busy", 32'(busy), 32'd0);
      check("stall after out_sum", 32'(out_sum), 32'd1000);
    end

    // Reset after the second of four beats, then a fresh one-operand run.
    begin
      vec_t v7;
      start     = 1'b1;
      len       = 8'd4;
      out_ready = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'd10;
      step();
      in_data  = 16'd20;
      step();
      check("mid partial", 32'(out_sum), 32'd30);
      in_data = 16'd30;
      rst     = 1'b1;
      #1;
      check("mid rst in_ready", 32'(in_ready), 32'd0);
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst out_valid", 32'(out_valid), 32'd0);
      check("mid rst out_sum", 32'(out_sum), 32'd0);
      check("mid rst out_ovf", 32'(out_ovf), 32'd0);
      step();
      check("mid rst no beat", 32'(out_valid), 32'd0);
      v7 = '{len: 8'd1, ops: {16'd0, 16'd0, 16'd0, 16'd7},
             sum_wrap: 16'd7, sum_sat: 16'd7, ovf: 1'b0};
      run_vec(v7, 100);
    end

    // Reset while holding a result in DONE discards it.
    start     = 1'b1;
    len       = 8'd0;
    out_ready = 1'b0;
    step();
    start = 1'b0;
    check("done_rst pre out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("done_rst out_valid", 32'(out_valid), 32'd0);
    check("done_rst busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla16_accumulator.md
CLA16_ACCUMULATOR -- requirements
Module: cla16_accumulator

Interface
REQ-001 SHALL have parameter LEN_W, default 8, giving the width of the operand-count input.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  begins a new accumulation; sampled only in IDLE.
REQ-005 SHALL have port len  input  LEN_W  number of operands to sum; sampled with start; 0 is legal.
REQ-006 SHALL have port in_valid  input  1  upstream operand valid.
REQ-007 SHALL have port in_data  input  16  upstream unsigned operand.
REQ-008 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_sum  output  16  accumulated sum.
REQ-012 SHALL have port out_ovf  output  1  sticky flag: some add produced carry-out.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL perform every 16-bit add through one instance of cla16, with a = accumulator, b = in_data, cin tied 0; its C output is the carry.
REQ-015 SHALL implement states IDLE, ACC and DONE, and no others.
REQ-016 In IDLE: in_ready=0 and out_valid=0; start=1 clears the accumulator and ovf, loads the remaining count from len, and moves to ACC (len!=0) or DONE (len==0) on the next cycle.
REQ-017 SHALL ignore start in ACC and DONE.
REQ-018 In ACC: in_ready=1; a beat is accepted only when in_valid && in_ready; an accepted beat updates acc to the CLA sum, ORs the carry into ovf, and decrements remaining.
REQ-019 Cycles with in_valid=0 in ACC SHALL leave acc, ovf and remaining unchanged.
REQ-020 SHALL sustain one accepted operand per cycle.
REQ-021 The beat accepted with remaining==1 SHALL move the block to DONE; out_valid SHALL rise on the next cycle (latency 1 cycle after the last beat).
REQ-022 In DONE: out_valid=1; out_sum and out_ovf SHALL be held stable until out_valid && out_ready, after which the state SHALL be IDLE on the next cycle.
REQ-023 If out_ready is already high on entry to DONE, DONE SHALL last exactly one cycle.
REQ-024 out_sum SHALL always reflect the accumulator register; out_ovf SHALL always reflect the sticky ovf register.
REQ-025 Without saturation, arithmetic SHALL wrap modulo 2^16.

Reset
REQ-026 While rst=1 at a clock edge: state SHALL go to IDLE; acc, ovf and remaining SHALL clear to 0; out_valid, in_ready and busy SHALL be 0.
REQ-027 rst SHALL take priority over start and every handshake.
REQ-028 Reset during ACC or DONE SHALL discard the partial or unconsumed result with no output beat.

Configuration
REQ-029 Macro CLA_ACC_SAT_EN defined: any accepted add with carry-out SHALL load acc with 16'hFFFF and set ovf.
REQ-030 Macro CLA_ACC_SAT_EN defined: once saturated, acc SHALL remain 16'hFFFF for the rest of the accumulation.
REQ-031 Macro CLA_ACC_SAT_EN undefined: acc SHALL take the wrapped CLA sum, ovf behaves as in REQ-018, and no saturation logic is present.

Verification
REQ-032 len=3; operands 1000, 2000, 3000 on consecutive cycles; out_ready=1 -> out_sum=6000, out_ovf=0, out_valid high exactly one cycle, one cycle after the third beat.
REQ-033 len=2; operands 48973, 57458 -> out_ovf=1; out_sum=40895 without CLA_ACC_SAT_EN; out_sum=65535 with it.
REQ-034 len=0; start at cycle t -> out_valid=1 at t+1 with out_sum=0 and out_ovf=0; in_ready never high.
REQ-035 len=4; in_valid toggling with gaps; out_ready low 5 cycles; start pulsed during DONE -> only valid beats counted, out_sum/out_valid stable while stalled, start ignored.
REQ-036 rst=1 for one cycle after the second of four beats -> next cycle busy=0, out_valid=0, out_sum=0; a new start with len=1, operand 7 -> out_sum=7.
